// File: rtl/edge_pkg.sv
// Shared edge-mode encoding for the multi-channel edge detector.
// One 2-bit mode per channel selects which filtered transitions raise a pulse.
package edge_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_OFF  = 2'b00;
    localparam edge_mode_t EDGE_RISE = 2'b01;
    localparam edge_mode_t EDGE_FALL = 2'b10;
    localparam edge_mode_t EDGE_BOTH = 2'b11;

    // True when a transition toward new_level qualifies under mode.
    function automatic logic mode_accepts(input edge_mode_t mode, input logic new_level);
        logic ok;
        ok = 1'b0;
        case (mode)
            EDGE_RISE: ok = new_level;
            EDGE_FALL: ok = ~new_level;
            EDGE_BOTH: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser chain, stability filter, edge qualification
// and a sticky pending flag that software clears with a strobe.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sig_in,
    input  edge_mode_t mode,
    input  logic       clear,
    output logic       level,
    output logic       pulse,
    output logic       pending,
    output logic       pending_next
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_d;
    logic                   pulse_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level;
        pulse_d = 1'b0;
        if (sync_out != level) begin
            // A pulse still showing blocks a back-to-back accept; only
            // reachable with a one-cycle filter.
            if (cnt_q == CNT_LAST && !pulse) begin
                level_d = sync_out;
                pulse_d = mode_accepts(mode, sync_out);
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pending_next = pulse_d | (pending & ~clear);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            cnt_q   <= cnt_d;
            level   <= level_d;
            pulse   <= pulse_d;
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Bank of independent filtered edge detectors with a summary pending flag.
// Per-channel work lives in edge_channel; this level only slices ports.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CHANNELS-1:0]   sig_in,
    input  logic [2*CHANNELS-1:0] mode_in,
    input  logic [CHANNELS-1:0]   clear_in,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   pending_out,
    output logic                  any_pending
);

    logic [CHANNELS-1:0] pending_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .sig_in      (sig_in[i]),
            .mode        (edge_mode_t'(mode_in[2*i +: 2])),
            .clear       (clear_in[i]),
            .level       (level_out[i]),
            .pulse       (pulse_out[i]),
            .pending     (pending_out[i]),
            .pending_next(pending_next[i])
        );
    end

    // Built from next-state bits so it lines up with pending_out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            any_pending <= 1'b0;
        end else begin
            any_pending <= |pending_next;
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector (4 channels, 2 sync stages, filter 3):
// directed literal scenarios followed by randomized traffic against a history model.
module tb_multi_edge_detector;

    localparam int C    = 4;
    localparam int S    = 2;
    localparam int F    = 3;
    localparam int W    = 3 * C + 1;
    localparam int HMAX = 8192;

    logic           clk;
    logic           reset_n;
    logic [C-1:0]   sig_in;
    logic [2*C-1:0] mode_in;
    logic [C-1:0]   clear_in;
    logic [C-1:0]   level_out;
    logic [C-1:0]   pulse_out;
    logic [C-1:0]   pending_out;
    logic           any_pending;

    int n_checks = 0;
    int n_errors = 0;

    multi_edge_detector #(
        .CHANNELS     (C),
        .SYNC_STAGES  (S),
        .FILTER_CYCLES(F)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .mode_in    (mode_in),
        .clear_in   (clear_in),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .pending_out(pending_out),
        .any_pending(any_pending)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an edge accepts a new level when the last F synchronised samples,
    // all taken since the latest reset, disagree with the current level.
    logic [C-1:0] in_hist [0:HMAX-1];
    int           edge_n   = 0;
    int           rst_edge = -1;
    bit           model_on = 0;
    logic [C-1:0] m_level, m_pulse, m_pend;
    logic [W-1:0] exp_q[$];

    function automatic logic sync_after(input int k, input int ch);
        if (k - (S - 1) > rst_edge) return in_hist[k - S + 1][ch];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (edge_n < HMAX) in_hist[edge_n] = sig_in;
        if (!reset_n) begin
            m_level  = '0;
            m_pulse  = '0;
            m_pend   = '0;
            rst_edge = edge_n;
            model_on = 1;
        end else if (model_on) begin
            for (int ch = 0; ch < C; ch++) begin
                bit         all_diff;
                logic       np;
                logic [1:0] md;
                all_diff = 1;
                np       = 1'b0;
                md       = mode_in[2*ch +: 2];
                for (int j = 1; j <= F; j++) begin
                    if (edge_n - j < rst_edge || sync_after(edge_n - j, ch) == m_level[ch])
                        all_diff = 0;
                end
                if (all_diff) begin
                    m_level[ch] = ~m_level[ch];
                    np = (md == 2'd3) || (md == 2'd1 && m_level[ch]) || (md == 2'd2 && !m_level[ch]);
                end
                m_pulse[ch] = np;
                m_pend[ch]  = np | (m_pend[ch] & ~clear_in[ch]);
            end
        end
        if (model_on) exp_q.push_back({m_level, m_pulse, m_pend, |m_pend});
    end

    // Scoreboard compare, every cycle once the model is live
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            exp_v = exp_q.pop_front();
            act_v = {level_out, pulse_out, pending_out, any_pending};
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL model_cmp edge %0d: got %0h expected %0h", edge_n, act_v, exp_v);
            end
        end
    end

    initial begin
        int hold [C];
        reset_n  = 1'b0;
        sig_in   = '0;
        mode_in  = '0;
        clear_in = '0;
        @(negedge clk);
        apply_reset(3);
        chk("reset_level", level_out, 0);
        chk("reset_pulse", pulse_out, 0);
        chk("reset_pending", pending_out, 0);
        chk("reset_any", any_pending, 0);

        // ch0 rising, latency S+F
        mode_in = 8'b00_00_00_01;
        sig_in  = 4'b0001;
        repeat (4) step();
        chk("t1_level_e4", level_out[0], 0);
        step();
        chk("t1_level_e5", level_out[0], 1);
        chk("t1_pulse_e5", pulse_out[0], 1);
        step();
        chk("t1_pulse_e6", pulse_out[0], 0);
        chk("t1_pending", pending_out[0], 1);
        chk("t1_any", any_pending, 1);

        // pending set and clear on the same edge
        clear_in = 4'b0001;
        step();
        clear_in = 4'b0000;
        chk("t2_cleared", pending_out[0], 0);
        mode_in = 8'b00_00_00_11;
        sig_in  = 4'b0000;
        repeat (4) step();
        clear_in = 4'b0001;
        step();
        chk("t2_pulse", pulse_out[0], 1);
        chk("t2_set_wins", pending_out[0], 1);
        step();
        clear_in = 4'b0000;
        chk("t2_clear_next", pending_out[0], 0);
        chk("t2_any_low", any_pending, 0);

        // ch1 glitch rejected, then real transitions
        mode_in = 8'b00_00_11_11;
        sig_in  = 4'b0010;
        repeat (2) step();
        sig_in = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_glitch_level", level_out[1], 0);
            chk("t3_glitch_pulse", pulse_out[1], 0);
        end
        sig_in = 4'b0010;
        repeat (5) step();
        chk("t3_rise_level", level_out[1], 1);
        chk("t3_rise_pulse", pulse_out[1], 1);
        step();
        chk("t3_rise_pulse_off", pulse_out[1], 0);
        sig_in = 4'b0000;
        repeat (5) step();
        chk("t3_fall_level", level_out[1], 0);
        chk("t3_fall_pulse", pulse_out[1], 1);
        step();

        // ch2 falling only, then mode change while stable
        mode_in = 8'b00_10_11_11;
        sig_in  = 4'b0100;
        repeat (5) step();
        chk("t4_rise_level", level_out[2], 1);
        chk("t4_rise_nopulse", pulse_out[2], 0);
        sig_in = 4'b0000;
        repeat (5) step();
        chk("t4_fall_level", level_out[2], 0);
        chk("t4_fall_pulse", pulse_out[2], 1);
        step();
        mode_in = 8'b00_01_11_11;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_mode_nopulse", pulse_out, 0);
        end

        // all channels together, then reset mid-filter
        mode_in = 8'hFF;
        sig_in  = 4'b1111;
        repeat (4) step();
        chk("t5_pulse_e4", pulse_out, 0);
        step();
        chk("t5_pulse_all", pulse_out, 4'b1111);
        chk("t5_level_all", level_out, 4'b1111);
        step();
        chk("t5_pulse_off", pulse_out, 0);
        sig_in = 4'b0000;
        apply_reset(2);
        sig_in = 4'b1111;
        repeat (2) step();
        reset_n = 1'b0;
        step();
        chk("t6_level", level_out, 0);
        chk("t6_pulse", pulse_out, 0);
        chk("t6_pending", pending_out, 0);
        chk("t6_any", any_pending, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_early_pulse", pulse_out, 0);
        end
        step();
        chk("t6_full_latency", pulse_out, 4'b1111);

        // randomized traffic
        for (int ch = 0; ch < C; ch++) hold[ch] = 0;
        for (int n = 0; n < 2500; n++) begin
            for (int ch = 0; ch < C; ch++) begin
                if (hold[ch] == 0) begin
                    sig_in[ch] = 1'($urandom_range(0, 1));
                    hold[ch]   = $urandom_range(1, 6);
                end else begin
                    hold[ch]--;
                end
                clear_in[ch] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 39) == 0) mode_in = 8'($urandom);
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end
        reset_n  = 1'b1;
        clear_in = '0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flop count per channel (2..4).
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, consecutive stable cycles required before a level change is accepted (1..255).
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port sig_in, input, CHANNELS, asynchronous raw inputs.
REQ-007 SHALL have port mode_in, input, 2*CHANNELS, per-channel edge mode; bits [2i+1:2i] belong to channel i.
REQ-008 SHALL have port clear_in, input, CHANNELS, per-channel pending-flag clear strobe.
REQ-009 SHALL have port level_out, output, CHANNELS, filtered, synchronised level.
REQ-010 SHALL have port pulse_out, output, CHANNELS, one-cycle pulse per qualifying edge.
REQ-011 SHALL have port pending_out, output, CHANNELS, sticky edge-seen flags.
REQ-012 SHALL have port any_pending, output, 1, OR of pending_out.

Function
REQ-013 Each channel SHALL pass sig_in through a SYNC_STAGES-deep flop chain; only the last stage feeds the filter.
REQ-014 Filter: a per-channel counter of width clog2(FILTER_CYCLES+1) SHALL increment while the sync output differs from level_out, and SHALL reset to 0 on any cycle it matches.
REQ-015 level_out SHALL toggle, and the counter return to 0, at the edge where the counter would reach FILTER_CYCLES; a difference shorter than FILTER_CYCLES cycles SHALL never change level_out.
REQ-016 Modes: 00 off, 01 rising, 10 falling, 11 both; pulse_out SHALL assert on the same edge level_out toggles, only if the transition direction matches the mode sampled on that edge.
REQ-017 pulse_out SHALL be registered, high exactly one cycle per accepted transition, never on consecutive cycles.
REQ-018 Latency: counting the first edge sampling a new stable sig_in as edge 1, level_out and pulse_out SHALL update at edge SYNC_STAGES+FILTER_CYCLES.
REQ-019 Mode changes SHALL NOT create pulses; mode off SHALL still let level_out track.
REQ-020 pending_out[i] SHALL set on pulse_out[i] and clear on clear_in[i]; simultaneous set and clear SHALL leave it set.
REQ-021 any_pending SHALL be a registered OR of next-state pending bits, coincident with pending_out.
REQ-022 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.

Reset
REQ-023 While reset_n is low at a clk edge, sync flops, counters, level_out, pulse_out, pending_out and any_pending SHALL become 0.
REQ-024 After reset, a high input SHALL be reported as a rising edge after the REQ-018 latency.
REQ-025 Reset asserted mid-filter SHALL discard partial counts; no pulse SHALL emerge from pre-reset state.

Structure
REQ-026 Package edge_pkg SHALL hold mode constants EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH and the 2-bit mode typedef.
REQ-027 Per-channel sync, filter, edge and pending logic SHALL live in sub-module edge_channel, instantiated CHANNELS times by generate; the top adds only port slicing and any_pending.

Verification (CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3)
REQ-028 ch0 mode 01, sig_in[0] 0->1 held -> level_out[0] and pulse_out[0] high at edge 5, pulse low at edge 6, pending_out[0]=1 and any_pending=1.
REQ-029 ch1 mode 11, glitch high for 2 cycles -> no level change, no pulse; then high 3+ cycles -> one pulse; then low -> second pulse.
REQ-030 ch2 mode 10, rising then falling -> pulse only on falling; mode switched 10->01 while level stable -> no pulse.
REQ-031 pending set and clear_in[0] asserted on the same edge -> pending_out[0] stays 1; clear next cycle -> 0, any_pending 0.
REQ-032 All four channels rise together, mode 11 -> pulse_out=4'b1111 in one cycle; reset_n low at edge 3 of the filter -> all outputs 0, no pulse after release until a full new latency elapses.
